// File: rtl/msx_clk_enable_pkg.sv
// -----------------------------------------------------------------------------
// msx_clk_enable_pkg
// Shared constants for the MSX clock-enable generator.
//   CLK_HZ    : frequency of the PLL output clock feeding the generator
//   FREQ_NUM  : numerator of the ce_vdp rate as a fraction of clk
//   FREQ_DEN  : denominator of that fraction (126 MHz * 15/88 = 21.477 MHz)
//   LOCK_WAIT : synchronized-lock cycles needed before sys_rst releases
//   CPU_DIV   : ce_vdp pulses per ce_cpu pulse in normal mode
// -----------------------------------------------------------------------------
package msx_clk_enable_pkg;

    localparam int CLK_HZ    = 126_000_000;
    localparam int FREQ_NUM  = 15;
    localparam int FREQ_DEN  = 88;
    localparam int LOCK_WAIT = 1024;
    localparam int CPU_DIV   = 6;

    // Accumulator must hold acc + num without overflow, where acc < den.
    function automatic int acc_width(input int den, input int num);
        return $clog2(den + num);
    endfunction

endpackage

// File: rtl/msx_clk_enable_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input level
//   q   : synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/msx_clk_enable.sv
// -----------------------------------------------------------------------------
// msx_clk_enable
// Derives the MSX core reset and clock enables from the 126 MHz PLL clock.
//   clk      : 126 MHz PLL output, the only clock
//   reset    : asynchronous active-high reset
//   pll_lock : PLL lock flag, asynchronous to clk
//   turbo    : 1 selects a CPU enable rate of CPU_DIV/2 ce_vdp pulses
//   sys_rst  : active-high synchronous reset for the MSX core
//   ce_vdp   : single-cycle enable at FREQ_NUM/FREQ_DEN of clk
//   ce_cpu   : single-cycle enable, coincident with a ce_vdp pulse
//   ce_psg   : single-cycle enable on every second ce_cpu, coincident with it
// -----------------------------------------------------------------------------
module msx_clk_enable #(
    parameter int FREQ_NUM  = msx_clk_enable_pkg::FREQ_NUM,
    parameter int FREQ_DEN  = msx_clk_enable_pkg::FREQ_DEN,
    parameter int LOCK_WAIT = msx_clk_enable_pkg::LOCK_WAIT,
    parameter int CPU_DIV   = msx_clk_enable_pkg::CPU_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    input  logic turbo,
    output logic sys_rst,
    output logic ce_vdp,
    output logic ce_cpu,
    output logic ce_psg
);

    import msx_clk_enable_pkg::acc_width;

    localparam int ACC_W     = acc_width(FREQ_DEN, FREQ_NUM);
    localparam int LOCK_W    = $clog2(LOCK_WAIT + 1);
    localparam int DIV_W     = $clog2(CPU_DIV + 1);
    localparam int TURBO_DIV = CPU_DIV / 2;

    logic              lock_s;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              sys_rst_q, sys_rst_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [DIV_W-1:0]  cpu_cnt_q, cpu_cnt_d, cpu_last;
    logic              turbo_q, turbo_d;
    logic              psg_tgl_q, psg_tgl_d;
    logic              ce_vdp_q, ce_vdp_d;
    logic              ce_cpu_q, ce_cpu_d;
    logic              ce_psg_q, ce_psg_d;
    logic              run;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Lock qualification. sys_rst also looks at lock_s directly so a lost lock
    // re-asserts it on the very next edge instead of waiting for the counter
    // to clear first.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        lock_cnt_d = '0;
        if (lock_s) begin
            lock_cnt_d = (lock_cnt_q == LOCK_W'(LOCK_WAIT)) ? lock_cnt_q
                                                            : lock_cnt_q + LOCK_W'(1);
        end
        sys_rst_d = !(lock_s && (lock_cnt_q == LOCK_W'(LOCK_WAIT)));
    end

    // Enable generation. Advancing only when sys_rst is low both now and next
    // cycle keeps every enable at zero in any cycle where sys_rst is high,
    // including the first cycle of a re-assertion.
    always_comb begin
        run      = !sys_rst_q && !sys_rst_d;
        acc_sum  = acc_q + ACC_W'(FREQ_NUM);
        cpu_last = turbo_q ? DIV_W'(TURBO_DIV - 1) : DIV_W'(CPU_DIV - 1);

        acc_d     = '0;
        cpu_cnt_d = '0;
        turbo_d   = turbo;      // divider sits at its wrap point while held
        psg_tgl_d = 1'b0;
        ce_vdp_d  = 1'b0;
        ce_cpu_d  = 1'b0;
        ce_psg_d  = 1'b0;

        if (run) begin
            cpu_cnt_d = cpu_cnt_q;
            turbo_d   = turbo_q;
            psg_tgl_d = psg_tgl_q;
            if (acc_sum >= ACC_W'(FREQ_DEN)) begin
                acc_d    = acc_sum - ACC_W'(FREQ_DEN);
                ce_vdp_d = 1'b1;
                if (cpu_cnt_q == cpu_last) begin
                    // Period boundary: the only point where turbo is taken.
                    cpu_cnt_d = '0;
                    turbo_d   = turbo;
                    ce_cpu_d  = 1'b1;
                    ce_psg_d  = psg_tgl_q;
                    psg_tgl_d = !psg_tgl_q;
                end else begin
                    cpu_cnt_d = cpu_cnt_q + DIV_W'(1);
                end
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt_q <= '0;
            sys_rst_q  <= 1'b1;
            acc_q      <= '0;
            cpu_cnt_q  <= '0;
            turbo_q    <= 1'b0;
            psg_tgl_q  <= 1'b0;
            ce_vdp_q   <= 1'b0;
            ce_cpu_q   <= 1'b0;
            ce_psg_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            sys_rst_q  <= sys_rst_d;
            acc_q      <= acc_d;
            cpu_cnt_q  <= cpu_cnt_d;
            turbo_q    <= turbo_d;
            psg_tgl_q  <= psg_tgl_d;
            ce_vdp_q   <= ce_vdp_d;
            ce_cpu_q   <= ce_cpu_d;
            ce_psg_q   <= ce_psg_d;
        end
    end

    assign sys_rst = sys_rst_q;
    assign ce_vdp  = ce_vdp_q;
    assign ce_cpu  = ce_cpu_q;
    assign ce_psg  = ce_psg_q;

endmodule

// File: tb/tb_msx_clk_enable.sv
// -----------------------------------------------------------------------------
// tb_msx_clk_enable
// Directed bench for msx_clk_enable with default parameters (15/88, 1024, 6).
// Outputs are sampled 1 ns after each rising edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_msx_clk_enable;

    logic clk = 1'b0;
    logic reset;
    logic pll_lock;
    logic turbo;
    logic sys_rst;
    logic ce_vdp;
    logic ce_cpu;
    logic ce_psg;

    int n_cmp = 0;
    int n_err = 0;

    msx_clk_enable dut (
        .clk      (clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .turbo    (turbo),
        .sys_rst  (sys_rst),
        .ce_vdp   (ce_vdp),
        .ce_cpu   (ce_cpu),
        .ce_psg   (ce_psg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until sys_rst drops; edges counts the first edge after the call
    // as 1. Any enable seen while sys_rst is high is counted in bad.
    task automatic wait_release(output int edges, output int bad);
        edges = 0;
        bad   = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            edges++;
            if (sys_rst === 1'b0) break;
            if (ce_vdp !== 1'b0 || ce_cpu !== 1'b0 || ce_psg !== 1'b0) bad++;
        end
    endtask

    task automatic count_window(input int n, output int vdp, output int cpu, output int psg,
                                output int first, output int v88, output int bad);
        vdp = 0; cpu = 0; psg = 0; first = 0; v88 = 0; bad = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (ce_vdp === 1'b1) begin
                vdp++;
                if (first == 0) first = i;
                if (i <= 88) v88++;
            end
            if (ce_cpu === 1'b1) cpu++;
            if (ce_psg === 1'b1) psg++;
            if ((ce_cpu === 1'b1 && ce_vdp !== 1'b1) || (ce_psg === 1'b1 && ce_cpu !== 1'b1)) bad++;
        end
    endtask

    // Counts ce_vdp pulses up to and including the next ce_cpu; turbo is
    // changed right after the switch_at-th ce_vdp of the period.
    task automatic run_period(input int switch_at, input logic new_turbo,
                              output int nvdp, output logic done);
        nvdp = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (ce_vdp === 1'b1) nvdp++;
            if (ce_cpu === 1'b1) done = 1'b1;
            else if (ce_vdp === 1'b1 && nvdp == switch_at) turbo = new_turbo;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, bad, vdp, cpu, psg, first, v88, nvdp;
        logic done;

        reset    = 1'b1;
        pll_lock = 1'b0;
        turbo    = 1'b0;
        #1;
        check("reset_sys_rst", sys_rst, 1);
        check("reset_ce_vdp", ce_vdp, 0);
        check("reset_ce_cpu", ce_cpu, 0);
        check("reset_ce_psg", ce_psg, 0);
        tick();
        tick();
        check("held_reset_sys_rst", sys_rst, 1);

        // Lock present at release: first sampling edge is edge 1, sys_rst
        // falls on edge 2 + 1024 + 1 = 1027.
        reset    = 1'b0;
        pll_lock = 1'b1;
        wait_release(edges, bad);
        check("release_edges", edges, 1027);
        check("release_ce_quiet", bad, 0);

        // Normal mode window: 1056 = 12 * 88 cycles.
        count_window(1056, vdp, cpu, psg, first, v88, bad);
        check("n_first_vdp", first, 6);
        check("n_vdp_first88", v88, 15);
        check("n_vdp", vdp, 180);
        check("n_cpu", cpu, 30);
        check("n_psg", psg, 15);
        check("n_coincident", bad, 0);

        // Window ended on a ce_cpu edge, so the next period starts clean.
        run_period(2, 1'b1, nvdp, done);
        check("t_up_old_done", done, 1);
        check("t_up_old_period", nvdp, 6);
        run_period(-1, 1'b1, nvdp, done);
        check("t_up_new_period", nvdp, 3);
        run_period(1, 1'b0, nvdp, done);
        check("t_dn_old_period", nvdp, 3);
        run_period(-1, 1'b0, nvdp, done);
        check("t_dn_new_period", nvdp, 6);

        // Lock loss for three sampling edges; turbo is on for the relock run.
        turbo    = 1'b1;
        pll_lock = 1'b0;
        tick();
        check("drop_edge1_sys_rst", sys_rst, 0);
        tick();
        tick();
        check("drop_edge3_sys_rst", sys_rst, 1);
        check("drop_edge3_ce_vdp", ce_vdp, 0);
        check("drop_edge3_ce_cpu", ce_cpu, 0);
        check("drop_edge3_ce_psg", ce_psg, 0);
        pll_lock = 1'b1;
        wait_release(edges, bad);
        check("relock_edges", edges, 1027);
        check("relock_ce_quiet", bad, 0);

        count_window(1056, vdp, cpu, psg, first, v88, bad);
        check("t_first_vdp", first, 6);
        check("t_vdp", vdp, 180);
        check("t_cpu", cpu, 60);
        check("t_psg", psg, 30);
        check("t_coincident", bad, 0);

        // Asynchronous reset between edges while ce_cpu is high.
        run_period(-1, 1'b1, nvdp, done);
        check("pre_areset_ce_cpu", ce_cpu, 1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_sys_rst", sys_rst, 1);
        check("areset_ce_vdp", ce_vdp, 0);
        check("areset_ce_cpu", ce_cpu, 0);
        check("areset_ce_psg", ce_psg, 0);
        tick();
        tick();
        turbo = 1'b0;
        reset = 1'b0;
        wait_release(edges, bad);
        check("post_areset_edges", edges, 1027);
        count_window(264, vdp, cpu, psg, first, v88, bad);
        check("post_areset_first_vdp", first, 6);
        check("post_areset_vdp", vdp, 45);
        check("post_areset_cpu", cpu, 7);
        check("post_areset_psg", psg, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/msx_clk_enable.md
MSX_CLK_ENABLE -- requirements
Module: msx_clk_enable

Interface
REQ-001 Parameter FREQ_NUM, default 15, SHALL set the numerator of the ce_vdp rate as a fraction of clk (126 MHz x 15/88 = 21.477 MHz).
REQ-002 Parameter FREQ_DEN, default 88, SHALL set the denominator of that fraction.
REQ-003 Parameter LOCK_WAIT, default 1024, SHALL set the number of consecutive synchronized-lock cycles required before sys_rst releases.
REQ-004 Parameter CPU_DIV, default 6, SHALL set the number of ce_vdp pulses per ce_cpu pulse in normal mode.
REQ-005 Port clk, input, 1 bit: the 126 MHz PLL output clock, the only clock.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port pll_lock, input, 1 bit: PLL lock flag, asynchronous to clk.
REQ-008 Port turbo, input, 1 bit: 1 selects a CPU enable rate of CPU_DIV/2.
REQ-009 Port sys_rst, output, 1 bit: active-high synchronous reset for the MSX core.
REQ-010 Port ce_vdp, output, 1 bit: single-cycle enable at the FREQ_NUM/FREQ_DEN rate.
REQ-011 Port ce_cpu, output, 1 bit: single-cycle enable, coincident with a ce_vdp pulse.
REQ-012 Port ce_psg, output, 1 bit: single-cycle enable on every second ce_cpu pulse, coincident with it.

Function
REQ-013 pll_lock SHALL pass through a 2-flop synchronizer; lock_s denotes the synchronizer output.
REQ-014 A lock counter SHALL clear whenever lock_s=0 and otherwise increment, saturating at LOCK_WAIT.
REQ-015 sys_rst SHALL be 1 while the lock counter is below LOCK_WAIT and 0 once it equals LOCK_WAIT, registered.
REQ-016 If lock_s falls, sys_rst SHALL re-assert on the next clk edge, and the counter SHALL restart from 0.
REQ-017 The phase accumulator SHALL satisfy 0 <= acc < FREQ_DEN and have width ceil(log2(FREQ_DEN+FREQ_NUM)).
REQ-018 On each cycle with sys_rst=0, the accumulator SHALL compute s = acc + FREQ_NUM.
REQ-019 If s >= FREQ_DEN, acc SHALL load s - FREQ_DEN and ce_vdp SHALL be 1 in the following cycle.
REQ-020 If s < FREQ_DEN, acc SHALL load s and ce_vdp SHALL be 0.
REQ-021 The design SHALL produce exactly FREQ_NUM ce_vdp pulses per FREQ_DEN cycles, with no drift.
REQ-022 A CPU divider counter SHALL advance on each ce_vdp pulse and wrap at CPU_DIV (turbo=0) or CPU_DIV/2 (turbo=1).
REQ-023 ce_cpu SHALL pulse on the ce_vdp cycle where the CPU divider wraps.
REQ-024 turbo SHALL be sampled only at a CPU divider wrap; a mid-period change SHALL take effect from the next period.
REQ-025 A 1-bit PSG toggle SHALL flip on each ce_cpu, and ce_psg SHALL pulse when ce_cpu=1 and the toggle=1.
REQ-026 While sys_rst=1, acc, the CPU divider and the PSG toggle SHALL hold at 0, and all ce_* outputs SHALL be 0.
REQ-027 The first ce_vdp pulse SHALL occur in the 6th cycle after sys_rst falls (acc sequence 15, 30, 45, 60, 75, then wrap to 2).

Reset
REQ-028 Asserting reset SHALL asynchronously drive sys_rst=1, ce_vdp=ce_cpu=ce_psg=0, and clear the synchronizer, lock counter, acc, divider and toggle.
REQ-029 After reset deasserts, the design SHALL follow the REQ-013..REQ-015 sequence; assertion of reset at any time mid-operation SHALL take priority over all other behaviour.

Structure
REQ-030 A shared package SHALL hold the constants CLK_HZ=126000000, FREQ_NUM, FREQ_DEN, LOCK_WAIT and CPU_DIV.
REQ-031 The synchronizer SHALL be the sub-module sync_2ff; all other logic SHALL be flat in msx_clk_enable.

Verification
REQ-032 Release reset with pll_lock=1 -> sys_rst falls exactly 2+1024 clk after the first sampling edge; ce_* = 0 until then.
REQ-033 Count 1056 cycles after release with turbo=0 -> exactly 180 ce_vdp, 30 ce_cpu and 15 ce_psg pulses.
REQ-034 Repeat the 1056-cycle count with turbo=1 -> exactly 180 ce_vdp, 60 ce_cpu and 30 ce_psg pulses.
REQ-035 Toggle turbo mid-period -> the current ce_cpu period completes at the old divisor and the next period uses the new divisor.
REQ-036 Drop pll_lock for 3 cycles during run -> sys_rst=1 within 3 edges and ce_*=0; after relock, sys_rst releases after 1026 cycles; first ce_vdp follows on the 6th cycle.
REQ-037 Assert reset mid-run asynchronously -> all outputs reach reset values before the next clk edge.
